// File: rtl/lives_pkg.sv
// ---------------------------------------------------------------------------
// lives_pkg
// Shared definitions for the lives / game-flow logic of the Pac-Man core.
//   lives_state_t : life-cycle states (ALIVE, DYING, INVULN, GAME_OVER)
//   HP_W          : width of the lives count seen by the hearts display
//   DEFAULT_*     : default frame-count constants shared with the game
//                   controller
//   timer_width() : width needed to count up to the longer frame window
// ---------------------------------------------------------------------------
package lives_pkg;

  typedef enum logic [1:0] {
    ALIVE     = 2'd0,
    DYING     = 2'd1,
    INVULN    = 2'd2,
    GAME_OVER = 2'd3
  } lives_state_t;

  localparam int HP_W = 2;

  localparam int DEFAULT_MAX_HP        = 3;
  localparam int DEFAULT_DEATH_FRAMES  = 60;
  localparam int DEFAULT_INVULN_FRAMES = 120;
  localparam int DEFAULT_BLINK_PERIOD  = 8;

  // The frame counter has to reach (window-1) of the longer window. A
  // one-frame window would give $clog2 = 0, so keep at least one bit.
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/lives_manager_if.sv
// ---------------------------------------------------------------------------
// lives_manager_if
// Bundles the game-flow inputs and the lives/status outputs of
// lives_manager.
//   master : game side (collision/score logic drives events, VGA drawers
//            and movement logic consume status)
//   slave  : lives_manager itself
// Signals:
//   startOfFrame  one-cycle pulse per video frame
//   collision     level, Pac-Man overlaps a hostile ghost
//   extraLife     one-cycle pulse granting one life
//   newGame       one-cycle pulse restarting the game
//   HP            current lives count
//   freeze        movement halt while dying / game over
//   invulnerable  post-respawn immunity window
//   pacmanVisible Pac-Man drawing enable (blinks while invulnerable)
//   deathPulse    one-cycle strobe when a life is lost
//   respawnPulse  one-cycle strobe when positions must reset
//   gameOver      high once HP reaches 0
// ---------------------------------------------------------------------------
interface lives_manager_if;
  import lives_pkg::*;

  logic            startOfFrame;
  logic            collision;
  logic            extraLife;
  logic            newGame;
  logic [HP_W-1:0] HP;
  logic            freeze;
  logic            invulnerable;
  logic            pacmanVisible;
  logic            deathPulse;
  logic            respawnPulse;
  logic            gameOver;

  modport master (
    output startOfFrame, collision, extraLife, newGame,
    input  HP, freeze, invulnerable, pacmanVisible,
           deathPulse, respawnPulse, gameOver
  );

  modport slave (
    input  startOfFrame, collision, extraLife, newGame,
    output HP, freeze, invulnerable, pacmanVisible,
           deathPulse, respawnPulse, gameOver
  );

endinterface

// File: rtl/lives_frame_timer.sv
// ---------------------------------------------------------------------------
// lives_frame_timer
// Counts startOfFrame pulses from 0 up to a runtime-selected terminal value,
// then wraps to 0 and strobes done on that same frame.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   clear           holds the count at 0 (window not running)
//   start_of_frame  one-cycle frame pulse
//   limit           terminal count = window length - 1, so a full window
//                   length that is a power of two still fits in CW bits
//   count           current frame index within the window
//   done            combinational strobe: this frame pulse ends the window
// ---------------------------------------------------------------------------
module lives_frame_timer #(
  parameter int CW = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          start_of_frame,
  input  logic [CW-1:0] limit,
  output logic [CW-1:0] count,
  output logic          done
);

  // done is combinational so the owner can change state on the very edge
  // that consumes the last frame pulse of the window.
  assign done = start_of_frame && !clear && (count == limit);

  // Wrapping at done means the next window always starts from 0 without an
  // extra clear cycle between DYING and INVULN.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (start_of_frame) begin
      count <= done ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/lives_manager.sv
// ---------------------------------------------------------------------------
// lives_manager
// Keeps the Pac-Man lives count and sequences the life-loss flow:
// collision -> frame-timed death freeze -> blinking invulnerability -> alive,
// or game over once the last life is lost. Also handles saturating extra
// lives and newGame restart. All outputs are registered.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    lives_manager_if.slave (frame/collision/extraLife/newGame in,
//          HP and game-flow status/strobes out)
// ---------------------------------------------------------------------------
module lives_manager
  import lives_pkg::*;
#(
  parameter int MAX_HP        = DEFAULT_MAX_HP,
  parameter int DEATH_FRAMES  = DEFAULT_DEATH_FRAMES,
  parameter int INVULN_FRAMES = DEFAULT_INVULN_FRAMES,
  parameter int BLINK_PERIOD  = DEFAULT_BLINK_PERIOD
) (
  input logic            clk,
  input logic            reset,
  lives_manager_if.slave bus
);

  localparam int CW = timer_width(DEATH_FRAMES, INVULN_FRAMES);

  localparam logic [HP_W-1:0] HP_MAX      = HP_W'(MAX_HP);
  localparam logic [HP_W-1:0] HP_ONE      = HP_W'(1);
  localparam logic [CW-1:0]   DEATH_LAST  = CW'(DEATH_FRAMES - 1);
  localparam logic [CW-1:0]   INVULN_LAST = CW'(INVULN_FRAMES - 1);
  localparam logic [31:0]     BLINK_DIV   = 32'(BLINK_PERIOD);
  localparam logic [31:0]     BLINK_LAST  = 32'(BLINK_PERIOD - 1);

  lives_state_t    state;
  logic [HP_W-1:0] hp;
  logic            freeze;
  logic            invulnerable;
  logic            pacman_visible;
  logic            death_pulse;
  logic            respawn_pulse;
  logic            game_over;

  logic            timer_clear;
  logic [CW-1:0]   timer_limit;
  logic [CW-1:0]   frame_count;
  logic            timer_done;
  logic            blink_edge;
  logic [HP_W-1:0] hp_inc;

  // The single timer serves both windows: it only runs in DYING/INVULN and
  // its terminal value follows the current window. newGame clears it along
  // with the FSM so a restart always begins from a fresh count.
  always_comb begin
    timer_clear = !((state == DYING) || (state == INVULN)) || bus.newGame;
    timer_limit = (state == DYING) ? DEATH_LAST : INVULN_LAST;
  end

  lives_frame_timer #(
    .CW (CW)
  ) u_timer (
    .clk            (clk),
    .reset          (reset),
    .clear          (timer_clear),
    .start_of_frame (bus.startOfFrame),
    .limit          (timer_limit),
    .count          (frame_count),
    .done           (timer_done)
  );

  // Visibility flips on the last frame of every blink period; the compare
  // is done at 32 bits so any BLINK_PERIOD value is handled safely.
  // hp_inc is the saturating extra-life value.
  always_comb begin
    blink_edge = ((32'(frame_count) % BLINK_DIV) == BLINK_LAST);
    hp_inc     = (hp >= HP_MAX) ? hp : hp + 1'b1;
  end

  // Life-cycle FSM. reset and newGame share one branch so both give the
  // same restart values; pending strobes are dropped with it. Strobes
  // default low each cycle so they last exactly one clock. In ALIVE an
  // accepted collision beats a same-cycle extraLife; in DYING/INVULN the
  // collision input is ignored, so a held collision costs only one life.
  always_ff @(posedge clk) begin
    if (reset || bus.newGame) begin
      state          <= ALIVE;
      hp             <= HP_MAX;
      freeze         <= 1'b0;
      invulnerable   <= 1'b0;
      pacman_visible <= 1'b1;
      death_pulse    <= 1'b0;
      respawn_pulse  <= 1'b0;
      game_over      <= 1'b0;
    end else begin
      death_pulse   <= 1'b0;
      respawn_pulse <= 1'b0;
      case (state)
        ALIVE: begin
          if (bus.collision) begin
            death_pulse <= 1'b1;
            freeze      <= 1'b1;
            if (hp <= HP_ONE) begin
              state     <= GAME_OVER;
              hp        <= '0;
              game_over <= 1'b1;
            end else begin
              state <= DYING;
              hp    <= hp - 1'b1;
            end
          end else if (bus.extraLife) begin
            hp <= hp_inc;
          end
        end

        DYING: begin
          if (bus.extraLife) begin
            hp <= hp_inc;
          end
          if (timer_done) begin
            state          <= INVULN;
            freeze         <= 1'b0;
            invulnerable   <= 1'b1;
            pacman_visible <= 1'b1;
            respawn_pulse  <= 1'b1;
          end
        end

        INVULN: begin
          if (bus.extraLife) begin
            hp <= hp_inc;
          end
          if (timer_done) begin
            state          <= ALIVE;
            invulnerable   <= 1'b0;
            pacman_visible <= 1'b1;
          end else if (bus.startOfFrame && blink_edge) begin
            pacman_visible <= ~pacman_visible;
          end
        end

        GAME_OVER: begin
          hp             <= '0;
          game_over      <= 1'b1;
          freeze         <= 1'b1;
          invulnerable   <= 1'b0;
          pacman_visible <= 1'b1;
        end

        default: begin
          state <= ALIVE;
        end
      endcase
    end
  end

  assign bus.HP            = hp;
  assign bus.freeze        = freeze;
  assign bus.invulnerable  = invulnerable;
  assign bus.pacmanVisible = pacman_visible;
  assign bus.deathPulse    = death_pulse;
  assign bus.respawnPulse  = respawn_pulse;
  assign bus.gameOver      = game_over;

endmodule

// File: tb/tb_lives_manager.sv
// ---------------------------------------------------------------------------
// tb_lives_manager
// Directed testbench for lives_manager with a small window configuration
// (MAX_HP=3, DEATH_FRAMES=4, INVULN_FRAMES=8, BLINK_PERIOD=2). Each step
// pushes the outputs expected after the next clock edge into a scoreboard
// queue; the entry is popped and compared once that edge has happened.
// ---------------------------------------------------------------------------
module tb_lives_manager;
  import lives_pkg::*;

  localparam int TB_MAX_HP = 3;
  localparam int TB_DEATH  = 4;
  localparam int TB_INVULN = 8;
  localparam int TB_BLINK  = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  lives_manager_if bus ();

  lives_manager #(
    .MAX_HP        (TB_MAX_HP),
    .DEATH_FRAMES  (TB_DEATH),
    .INVULN_FRAMES (TB_INVULN),
    .BLINK_PERIOD  (TB_BLINK)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string      tag;
    logic [1:0] hp;
    logic       fr;
    logic       inv;
    logic       vis;
    logic       dp;
    logic       rp;
    logic       go;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Pac-Man visibility after each INVULN frame pulse (index = frame in the
  // window). Together with the visible frame entering INVULN this yields a
  // per-frame pattern of 1,1,0,0,1,1,0,0 for a blink period of 2.
  bit   vis_tab [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  task automatic cmp(input string tag, input string fld,
                     input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s.%s observed=%0d expected=%0d", tag, fld, obs, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    cmp(e.tag, "HP",            bus.HP,                  e.hp);
    cmp(e.tag, "freeze",        {1'b0, bus.freeze},      {1'b0, e.fr});
    cmp(e.tag, "invulnerable",  {1'b0, bus.invulnerable},{1'b0, e.inv});
    cmp(e.tag, "pacmanVisible", {1'b0, bus.pacmanVisible},{1'b0, e.vis});
    cmp(e.tag, "deathPulse",    {1'b0, bus.deathPulse},  {1'b0, e.dp});
    cmp(e.tag, "respawnPulse",  {1'b0, bus.respawnPulse},{1'b0, e.rp});
    cmp(e.tag, "gameOver",      {1'b0, bus.gameOver},    {1'b0, e.go});
  endtask

  task automatic expectOut(input string tag, input logic [1:0] hp,
                           input logic fr, input logic inv, input logic vis,
                           input logic dp, input logic rp, input logic go);
    exp_t e;
    e.tag = tag; e.hp = hp; e.fr = fr; e.inv = inv;
    e.vis = vis; e.dp = dp; e.rp = rp; e.go = go;
    sb.push_back(e);
  endtask

  // One clock of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic applyStimulus(input logic sof, input logic col,
                               input logic xl, input logic ng,
                               input logic rst);
    bus.startOfFrame = sof;
    bus.collision    = col;
    bus.extraLife    = xl;
    bus.newGame      = ng;
    reset            = rst;
    @(posedge clk);
    #1;
    bus.startOfFrame = 1'b0;
    bus.extraLife    = 1'b0;
    bus.newGame      = 1'b0;
    reset            = 1'b0;
    checkOutput();
  endtask

  // DYING window: freeze for DEATH-1 frames, respawn on the last one.
  task automatic dyingWindow(input logic col, input logic [1:0] hp);
    for (int k = 0; k < TB_DEATH; k++) begin
      if (k < TB_DEATH - 1) expectOut("dying_sof", hp, 1, 0, 1, 0, 0, 0);
      else                  expectOut("respawn",   hp, 0, 1, 1, 0, 1, 0);
      applyStimulus(1'b1, col, 1'b0, 1'b0, 1'b0);
      if (k < TB_DEATH - 1) expectOut("dying_idle",   hp, 1, 0, 1, 0, 0, 0);
      else                  expectOut("respawn_idle", hp, 0, 1, 1, 0, 0, 0);
      applyStimulus(1'b0, col, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // INVULN window: blink per vis_tab, back to ALIVE on the last frame. With
  // collision held, the cycle after the last frame belongs to the caller.
  task automatic invulnWindow(input logic col, input logic [1:0] hp);
    logic inv;
    for (int k = 0; k < TB_INVULN; k++) begin
      inv = (k < TB_INVULN - 1);
      expectOut("invuln_sof", hp, 0, inv, vis_tab[k], 0, 0, 0);
      applyStimulus(1'b1, col, 1'b0, 1'b0, 1'b0);
      if ((k < TB_INVULN - 1) || !col) begin
        expectOut("invuln_idle", hp, 0, inv, vis_tab[k], 0, 0, 0);
        applyStimulus(1'b0, col, 1'b0, 1'b0, 1'b0);
      end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.startOfFrame = 1'b0;
    bus.collision    = 1'b0;
    bus.extraLife    = 1'b0;
    bus.newGame      = 1'b0;
    reset            = 1'b1;

    // Reset, then idle frames with no pulses.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    expectOut("reset", 2'd3, 0, 0, 1, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      expectOut("idle_sof", 2'd3, 0, 0, 1, 0, 0, 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      expectOut("idle", 2'd3, 0, 0, 1, 0, 0, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Single-cycle collision.
    expectOut("hit", 2'd2, 1, 0, 1, 1, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expectOut("hit_after", 2'd2, 1, 0, 1, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    dyingWindow(1'b0, 2'd2);
    invulnWindow(1'b0, 2'd2);

    // Restart, then collision held across both windows.
    expectOut("newgame", 2'd3, 0, 0, 1, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    expectOut("held_hit", 2'd2, 1, 0, 1, 1, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expectOut("held_after", 2'd2, 1, 0, 1, 0, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    dyingWindow(1'b1, 2'd2);
    invulnWindow(1'b1, 2'd2);
    expectOut("relose", 2'd1, 1, 0, 1, 1, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expectOut("relose_after", 2'd1, 1, 0, 1, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Three separated collisions down to game over.
    expectOut("newgame2", 2'd3, 0, 0, 1, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int n = 2; n >= 1; n--) begin
      expectOut("sep_hit", 2'(n), 1, 0, 1, 1, 0, 0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      expectOut("sep_after", 2'(n), 1, 0, 1, 0, 0, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      dyingWindow(1'b0, 2'(n));
      invulnWindow(1'b0, 2'(n));
    end
    expectOut("gameover", 2'd0, 1, 0, 1, 1, 0, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expectOut("go_hold", 2'd0, 1, 0, 1, 0, 0, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      expectOut("go_xl", 2'd0, 1, 0, 1, 0, 0, 1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      expectOut("go_frame", 2'd0, 1, 0, 1, 0, 0, 1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    expectOut("restart", 2'd3, 0, 0, 1, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // extraLife saturation and priority against collision.
    expectOut("xl_sat", 2'd3, 0, 0, 1, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expectOut("hit_for_xl", 2'd2, 1, 0, 1, 1, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expectOut("hit_for_xl_after", 2'd2, 1, 0, 1, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    dyingWindow(1'b0, 2'd2);
    invulnWindow(1'b0, 2'd2);
    expectOut("xl_col", 2'd1, 1, 0, 1, 1, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // extraLife accepted while dying, saturating at MAX_HP.
    expectOut("xl_dying1", 2'd2, 1, 0, 1, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expectOut("xl_dying2", 2'd3, 1, 0, 1, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expectOut("xl_dying_sat", 2'd3, 1, 0, 1, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset on the second DYING frame; no respawn may follow.
    expectOut("dying_f1", 2'd3, 1, 0, 1, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expectOut("dying_f1_idle", 2'd3, 1, 0, 1, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expectOut("mid_reset", 2'd3, 0, 0, 1, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      expectOut("post_reset_sof", 2'd3, 0, 0, 1, 0, 0, 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      expectOut("post_reset", 2'd3, 0, 0, 1, 0, 0, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
